shift_pipe: RTL and testbench
=============================

// Module: shift_pipe
// PURPOSE
//   Parametrised, pipelined barrel shifter for the RISC ALU datapath; successor to the
//   fixed 32-bit combinational left shifter. Adds SRL/SRA modes, a valid/ready handshake
//   and a configurable register depth, and keeps shift-amount overflow detection.
//   Sits between operand fetch and ALU result mux; accepts one op per cycle when not stalled.
// PARAMETERS
//   WIDTH   32  data width; power of 2, >= 8
//   STAGES  2   pipeline register stages, 1..$clog2(WIDTH); sets latency
//   SHW     $clog2(WIDTH)  localparam, effective shift-amount width (not overridable)
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input op valid
//   in_ready   out  1      block can accept input this cycle
//   in_a       in   WIDTH  operand to shift
//   in_b       in   WIDTH  shift amount (full word; upper bits drive overflow)
//   in_op      in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR (see CONFIGURATION)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_y      out  WIDTH  shifted result
//   out_ovf    out  1      in_b >= WIDTH was seen for this result
// BEHAVIOUR
//   - Reset (async assert, sync release): all stage valids 0, out_valid=0, out_y=0,
//     out_ovf=0; in_ready=1 in the first cycle after release.
//   - Transfer on valid&ready at both ports. Latency exactly STAGES cycles with no stall.
//   - Per-stage ready: ready[i] = !valid[i] | ready[i+1]; ready[STAGES]=out_ready;
//     in_ready=ready[0]. Bubbles collapse; full throughput 1/cycle while out_ready=1.
//   - Stalled stages hold data/valid unchanged; out_y/out_ovf stable while out_valid&!out_ready.
//   - Overflow ovf = |in_b[WIDTH-1:SHW], computed at input, carried down the pipe.
//     ovf=1: SLL/SRL -> 0; SRA -> {WIDTH{in_a[WIDTH-1]}}; ROR -> ignores ovf, uses in_b[SHW-1:0].
//   - ovf=0: shift by in_b[SHW-1:0]; SRA sign-fills from in_a[WIDTH-1]; shift by 0 -> in_a.
//   - Barrel levels (2^k, k=0..SHW-1) split across stages, ceil(SHW/STAGES) levels per stage,
//     LSB levels first; op, sign and ovf travel with data.
//   - Input and output handshake same cycle: both complete; occupancy unchanged.
//   - Reset mid-operation: all in-flight ops discarded, no partial result emitted.
// CONFIGURATION
//   SHIFT_ROTATE_EN defined: in_op=11 performs rotate-right by in_b[SHW-1:0].
//   SHIFT_ROTATE_EN undefined: in_op=11 yields out_y=0, out_ovf=0; rotate muxing not built.
// STRUCTURE
//   shift_pkg: op encodings (OP_SLL/OP_SRL/OP_SRA/OP_ROR), per-stage level-count function.
//   Sub-module shift_stage: one register slot plus its combinational barrel levels,
//   parametrised by first level index and level count; shift_pipe generates STAGES of them.
// TESTING
//   1 WIDTH=32,STAGES=2: SLL a=0x0000_0001,b=31 -> y=0x8000_0000, ovf=0, 2 cycles later.
//   2 SRA a=0x8000_0010,b=4 -> 0xF800_0001; SRA b=0x20 -> 0xFFFF_FFFF, ovf=1; SRL b=0x100 -> 0.
//   3 Back-to-back 8 ops, out_ready=1 -> 8 results on consecutive cycles, in order.
//   4 Hold out_ready=0 after 2 ops -> in_ready drops when full; outputs stable; release -> no loss/dup.
//   5 SHIFT_ROTATE_EN: ROR a=0x0000_00F1,b=0x24 -> 0x1000_000F, ovf=1; undefined -> y=0.
//   6 Assert rst_n=0 with 2 ops in flight -> out_valid=0 immediately; no result after release.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and the helpers
// that split the barrel levels across pipeline stages.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    function automatic int levels_per_stage(input int shw, input int stages);
        return (shw + stages - 1) / stages;
    endfunction

    function automatic int stage_first(input int stage, input int shw, input int stages);
        return stage * levels_per_stage(shw, stages);
    endfunction

    // Later stages may own fewer levels (or none) when SHW does not divide evenly.
    function automatic int stage_levels(input int stage, input int shw, input int stages);
        int rem;
        rem = shw - stage_first(stage, shw, stages);
        if (rem <= 0) return 0;
        if (rem > levels_per_stage(shw, stages)) return levels_per_stage(shw, stages);
        return rem;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline slot: COUNT barrel levels starting at level FIRST, then a register with
// valid/ready flow control. Rotate levels exist only when SHIFT_ROTATE_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int FIRST = 0,
    parameter int COUNT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  shift_op_e        in_op,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_amt,
    output shift_op_e        out_op,
    output logic             out_ovf
);

    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   sel;

    // sel is walked LSB-first so each level only ever inspects bit 0.
    always_comb begin
        shifted = in_data;
        sel     = in_amt >> FIRST;
        for (int j = 0; j < COUNT; j++) begin
            if (sel[0]) begin
                case (in_op)
                    OP_SLL:  shifted = shifted << (1 << (FIRST + j));
                    OP_SRL:  shifted = shifted >> (1 << (FIRST + j));
                    OP_SRA:  shifted = $signed(shifted) >>> (1 << (FIRST + j));
`ifdef SHIFT_ROTATE_EN
                    OP_ROR:  shifted = (shifted >> (1 << (FIRST + j)))
                                     | (shifted << (WIDTH - (1 << (FIRST + j))));
`endif
                    default: ;
                endcase
            end
            sel = sel >> 1;
        end
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_op    <= OP_SLL;
            out_ovf   <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= shifted;
                out_amt  <= in_amt;
                out_op   <= in_op;
                out_ovf  <= in_ovf;
            end
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA(/ROR) barrel shifter with valid/ready handshake and STAGES latency.
// Define SHIFT_ROTATE_EN to build the rotate-right path; otherwise op 11 returns zero.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_ovf
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] data_s  [0:STAGES];
    logic [SHW-1:0]   amt_s   [0:STAGES];
    shift_op_e        op_s    [0:STAGES];
    logic             ovf_s   [0:STAGES];
    logic             valid_s [0:STAGES];
    logic             ready_s [0:STAGES];

    logic [WIDTH-1:0] data_c;
    logic [SHW-1:0]   amt_c;
    shift_op_e        op_c;
    logic             ovf_c;

    // Overflowed shifts are resolved up front by replacing the operand with its saturated
    // value; every later level then leaves it unchanged regardless of the amount bits.
    always_comb begin
        ovf_c  = |in_b[WIDTH-1:SHW];
        amt_c  = in_b[SHW-1:0];
        op_c   = shift_op_e'(in_op);
        data_c = in_a;
        case (op_c)
            OP_SLL, OP_SRL: if (ovf_c) data_c = '0;
            OP_SRA:         if (ovf_c) data_c = {WIDTH{in_a[WIDTH-1]}};
            default: begin
`ifndef SHIFT_ROTATE_EN
                data_c = '0;
                amt_c  = '0;
                ovf_c  = 1'b0;
`endif
            end
        endcase
    end

    assign data_s[0]       = data_c;
    assign amt_s[0]        = amt_c;
    assign op_s[0]         = op_c;
    assign ovf_s[0]        = ovf_c;
    assign valid_s[0]      = in_valid;
    assign in_ready        = ready_s[0];
    assign ready_s[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .FIRST (stage_first(i, SHW, STAGES)),
            .COUNT (stage_levels(i, SHW, STAGES))
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (valid_s[i]),
            .in_ready  (ready_s[i]),
            .in_data   (data_s[i]),
            .in_amt    (amt_s[i]),
            .in_op     (op_s[i]),
            .in_ovf    (ovf_s[i]),
            .out_valid (valid_s[i+1]),
            .out_ready (ready_s[i+1]),
            .out_data  (data_s[i+1]),
            .out_amt   (amt_s[i+1]),
            .out_op    (op_s[i+1]),
            .out_ovf   (ovf_s[i+1])
        );
    end

    assign out_valid = valid_s[STAGES];
    assign out_y     = data_s[STAGES];
    assign out_ovf   = ovf_s[STAGES];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed plus randomized checks of shift_pipe (WIDTH=32, STAGES=2) against a
// scoreboard fed by an arithmetic reference model.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_ovf;

    shift_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          errors  = 0;
    int          checks  = 0;
    int          cyc     = 0;
    bit          lat_chk = 1'b0;
    bit          stalled = 1'b0;
    logic [31:0] held_y;
    logic        held_ovf;

    // Reference: plain arithmetic on the full shift amount, rotate via a doubled word.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] op,
                                  output logic [31:0] y, output logic o);
        int          s;
        bit          big;
        logic [63:0] dbl;
        s   = int'(b % 32);
        big = (b > 32'd31);
        o   = big;
        case (op)
            2'b00: y = big ? 32'h0 : (a << s);
            2'b01: y = big ? 32'h0 : (a >> s);
            2'b10: y = big ? {32{a[31]}} : 32'($signed(a) >>> s);
            default: begin
`ifdef SHIFT_ROTATE_EN
                dbl = {a, a} >> s;
                y   = dbl[31:0];
`else
                y = 32'h0;
                o = 1'b0;
`endif
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive, let logic settle, log handshakes, then advance.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic ordy,
                        input bit dir, input logic [31:0] dy, input logic dovf);
        exp_t e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        #3;
        if (stalled) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_y", out_y, held_y);
            chk("hold_ovf", 32'(out_ovf), 32'(held_ovf));
        end
        if (in_valid && in_ready) begin
            if (dir) begin
                e.y   = dy;
                e.ovf = dovf;
            end else begin
                model(a, b, op, e.y, e.ovf);
            end
            e.cyc = cyc;
            q.push_back(e);
        end
        if (out_valid && out_ready) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL extra_out: observed=%h expected=no result", out_y);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_y", out_y, e.y);
                chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
                if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'(STAGES));
            end
        end
        stalled  = out_valid && !out_ready;
        held_y   = out_y;
        held_ovf = out_ovf;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, 2'b00, ordy, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] dy, input logic dovf);
        step(1'b1, a, b, op, 1'b1, 1'b1, dy, dovf);
    endtask

    task automatic send_rand(input logic ordy);
        logic [31:0] b;
        b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
        step(1'b1, $urandom, b, 2'($urandom_range(0, 3)), ordy, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", out_y, 32'h0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed values with known answers, unstalled so latency is exact.
        lat_chk = 1'b1;
        send(32'h0000_0001, 32'd31, OP_SLL, 32'h8000_0000, 1'b0);
        send(32'h8000_0010, 32'd4, OP_SRA, 32'hF800_0001, 1'b0);
        send(32'h8000_0010, 32'h20, OP_SRA, 32'hFFFF_FFFF, 1'b1);
        send(32'h1234_5678, 32'h100, OP_SRL, 32'h0, 1'b1);
`ifdef SHIFT_ROTATE_EN
        send(32'h0000_00F1, 32'h24, OP_ROR, 32'h1000_000F, 1'b1);
`else
        send(32'h0000_00F1, 32'h24, OP_ROR, 32'h0, 1'b0);
`endif
        send(32'hDEAD_BEEF, 32'd0, OP_SRL, 32'hDEAD_BEEF, 1'b0);
        send(32'h7000_0000, 32'd31, OP_SRA, 32'h0, 1'b0);
        drain();

        // Eight back-to-back random ops; latency check proves consecutive in-order results.
        for (int i = 0; i < 8; i++) send_rand(1'b1);
        drain();

        // Back-pressure: fill the pipe, hold, then release.
        lat_chk = 1'b0;
        send_rand(1'b0);
        send_rand(1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'hCAFE_F00D, 32'd8, OP_SRL, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'hCAFE_F00D, 32'd8, OP_SRL, 1'b1, 1'b0, 32'h0, 1'b0);
        drain();

        // Random traffic with random stalls.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) send_rand(1'($urandom_range(0, 2) != 0));
            else idle(1'($urandom_range(0, 2) != 0));
        end
        drain();

        // Reset with two ops in flight: both must vanish.
        send_rand(1'b1);
        send_rand(1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_y", out_y, 32'h0);
        q.delete();
        stalled  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
